cpu_trace_buffer: RTL and testbench

- Parametrised, synthesizable trace-capture block for the single-cycle CPU; replaces free-running clock-and-watch testbenches with recorded, replayable execution history.
- Taps the CPU's debug outputs (PC, opcode, register write address/data) each cycle.
- Stores register-writeback events in a circular buffer, detects program halt, then drains entries oldest-first over a valid/ready port to a bench or debug UART.

---
 rtl/cpu_dbg_pkg.sv | 28 ++
 rtl/trace_ram.sv | 25 ++
 rtl/cpu_trace_buffer.sv | 157 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and defaults for the single-cycle CPU debug and trace blocks.
package cpu_dbg_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [5:0] DEF_HALT_OP = 6'b111111;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    // Field order matches the packed storage word: pc in the top bits, data in the bottom.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_REG_W-1:0]  waddr;
        logic [DEF_DATA_W-1:0] wd;
    } trace_entry_t;

    function automatic int entry_width(input int addr_w, input int reg_w, input int data_w);
        return addr_w + reg_w + data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers in the parent.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures CPU register-writeback events into a circular buffer until halt,
// then drains them oldest-first over a valid/ready port.
module cpu_trace_buffer
    import cpu_dbg_pkg::*;
#(
    parameter int         ADDR_W       = 32,
    parameter int         DATA_W       = 32,
    parameter int         REG_W        = 5,
    parameter int         DEPTH        = 16,
    parameter logic [5:0] HALT_OP      = DEF_HALT_OP,
    parameter int         STALL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [5:0]               op_i,
    input  logic                     reg_we_i,
    input  logic [REG_W-1:0]         waddr_i,
    input  logic [DATA_W-1:0]        wd_i,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [REG_W-1:0]         rd_waddr,
    output logic [DATA_W-1:0]        rd_wd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted,
    output logic                     overflow,
    output logic [31:0]              cycle_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(ADDR_W, REG_W, DATA_W);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    trace_state_t state, next_state;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]  prev_pc;
    logic               prev_valid;
    logic [STALL_W-1:0] stall_cnt;
    logic [ENTRY_W-1:0] rd_entry;

    logic capture_active;
    logic do_write;
    logic full;
    logic pc_same;
    logic halt_now;
    logic pop;

    assign capture_active = (state == CAPTURE) && en;
    assign do_write       = capture_active && reg_we_i;
    assign full           = (count == CNT_W'(DEPTH));
    assign pc_same        = prev_valid && (pc_i == prev_pc);
    // stall_cnt holds the number of equal cycles already seen, so this cycle is the last one needed.
    assign halt_now       = capture_active &&
                            ((op_i == HALT_OP) ||
                             (pc_same && (stall_cnt == STALL_W'(STALL_CYCLES - 1))));
    assign rd_valid       = (state == DRAIN) && (count != '0);
    assign pop            = rd_valid && rd_ready;

    trace_ram #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_ram (
        .clk  (clk),
        .we   (do_write),
        .waddr(wr_ptr),
        .wdata({pc_i, waddr_i, wd_i}),
        .raddr(rd_ptr),
        .rdata(rd_entry)
    );

    assign rd_pc    = rd_valid ? rd_entry[ENTRY_W-1 -: ADDR_W] : '0;
    assign rd_waddr = rd_valid ? rd_entry[DATA_W +: REG_W]     : '0;
    assign rd_wd    = rd_valid ? rd_entry[DATA_W-1:0]          : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARMED;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ARMED;
        end else begin
            case (state)
                ARMED:   if (en) next_state = CAPTURE;
                CAPTURE: if (halt_now) next_state = DRAIN;
                DRAIN:   if ((count == '0) || (pop && (count == CNT_W'(1)))) next_state = DONE;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            halted     <= 1'b0;
            overflow   <= 1'b0;
            cycle_cnt  <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            halted     <= 1'b0;
            overflow   <= 1'b0;
            cycle_cnt  <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if ((state == ARMED) && en) begin
                prev_valid <= 1'b0;
                stall_cnt  <= '0;
            end
            if (capture_active) begin
                if (cycle_cnt != 32'hFFFF_FFFF) begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
                prev_pc    <= pc_i;
                prev_valid <= 1'b1;
                stall_cnt  <= pc_same ? stall_cnt + STALL_W'(1) : '0;
                if (halt_now) begin
                    halted <= 1'b1;
                end
            end
            // A full buffer keeps the newest DEPTH events by dropping the oldest.
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (full) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed scoreboard bench for cpu_trace_buffer: capture, wrap, stall halt,
// backpressure, clear mid-drain and asynchronous reset.
module tb_cpu_trace_buffer;

    localparam int         DEPTH = 16;
    localparam logic [5:0] HALT  = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        clear;
    logic [31:0] pc_i;
    logic [5:0]  op_i;
    logic        reg_we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wd_i;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wd;
    logic [4:0]  count;
    logic        halted;
    logic        overflow;
    logic [31:0] cycle_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wd;
    } entry_t;

    entry_t sb[$];
    logic   model_cap;
    logic   exp_overflow;
    int     errors = 0;
    int     checks = 0;

    cpu_trace_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (clear),
        .pc_i     (pc_i),
        .op_i     (op_i),
        .reg_we_i (reg_we_i),
        .waddr_i  (waddr_i),
        .wd_i     (wd_i),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_waddr (rd_waddr),
        .rd_wd    (rd_wd),
        .count    (count),
        .halted   (halted),
        .overflow (overflow),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one CPU cycle; record the event in the scoreboard when the model is capturing.
    task automatic apply_stimulus(input logic e, input logic we, input logic [31:0] pc,
                                  input logic [5:0] op, input logic [4:0] wa, input logic [31:0] wd);
        entry_t ent;
        en       = e;
        reg_we_i = we;
        pc_i     = pc;
        op_i     = op;
        waddr_i  = wa;
        wd_i     = wd;
        if (model_cap && e && we) begin
            ent.pc    = pc;
            ent.waddr = wa;
            ent.wd    = wd;
            sb.push_back(ent);
            if (sb.size() > DEPTH) begin
                void'(sb.pop_front());
                exp_overflow = 1'b1;
            end
        end
        tick();
    endtask

    task automatic drain_step(input logic ready, input string tag);
        rd_ready = ready;
        check_output({tag, "_valid"}, 64'(rd_valid), 64'(sb.size() > 0));
        check_output({tag, "_count"}, 64'(count), 64'(sb.size()));
        if (sb.size() > 0) begin
            check_output({tag, "_pc"}, 64'(rd_pc), 64'(sb[0].pc));
            check_output({tag, "_waddr"}, 64'(rd_waddr), 64'(sb[0].waddr));
            check_output({tag, "_wd"}, 64'(rd_wd), 64'(sb[0].wd));
        end
        tick();
        if (ready && (sb.size() > 0)) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        en       = 1'b0;
        reg_we_i = 1'b0;
        rd_ready = 1'b0;
        tick();
        clear        = 1'b0;
        sb.delete();
        exp_overflow = 1'b0;
        model_cap    = 1'b0;
    endtask

    task automatic enter_capture(input logic [31:0] pc);
        model_cap = 1'b0;
        apply_stimulus(1'b1, 1'b0, pc, 6'd0, 5'd0, 32'd0);
        model_cap = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        clear        = 1'b0;
        pc_i         = '0;
        op_i         = '0;
        reg_we_i     = 1'b0;
        waddr_i      = '0;
        wd_i         = '0;
        rd_ready     = 1'b0;
        model_cap    = 1'b0;
        exp_overflow = 1'b0;

        repeat (2) tick();
        check_output("rst_count", 64'(count), 64'd0);
        check_output("rst_halted", 64'(halted), 64'd0);
        check_output("rst_overflow", 64'(overflow), 64'd0);
        check_output("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check_output("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_output("rst_rd_pc", 64'(rd_pc), 64'd0);
        reset = 1'b0;
        tick();

        // Basic capture: three writes then the halt opcode.
        enter_capture(32'h0);
        apply_stimulus(1'b1, 1'b1, 32'h00, 6'd0, 5'd1, 32'h11);
        check_output("t1_count_latency", 64'(count), 64'd1);
        apply_stimulus(1'b1, 1'b1, 32'h04, 6'd0, 5'd2, 32'h22);
        apply_stimulus(1'b1, 1'b1, 32'h08, 6'd0, 5'd3, 32'h33);
        apply_stimulus(1'b1, 1'b0, 32'h0C, HALT, 5'd0, 32'h0);
        model_cap = 1'b0;
        en        = 1'b0;
        check_output("t1_halted", 64'(halted), 64'd1);
        check_output("t1_count", 64'(count), 64'd3);
        check_output("t1_cycle_cnt", 64'(cycle_cnt), 64'd4);
        check_output("t1_overflow", 64'(overflow), 64'd0);
        repeat (3) drain_step(1'b1, "t1_drain");
        apply_stimulus(1'b1, 1'b1, 32'h10, 6'd0, 5'd4, 32'h44);
        check_output("t1_done_valid", 64'(rd_valid), 64'd0);
        check_output("t1_done_count", 64'(count), 64'd0);
        check_output("t1_done_halted", 64'(halted), 64'd1);

        // Wrap and overflow: 20 writes into 16 entries.
        do_clear();
        check_output("t2_clr_halted", 64'(halted), 64'd0);
        check_output("t2_clr_cycle_cnt", 64'(cycle_cnt), 64'd0);
        enter_capture(32'h0);
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(1'b1, 1'b1, 32'(i * 4), 6'd0, 5'(i), 32'(i));
        end
        apply_stimulus(1'b1, 1'b0, 32'h100, HALT, 5'd0, 32'h0);
        model_cap = 1'b0;
        en        = 1'b0;
        check_output("t2_overflow", 64'(overflow), 64'(exp_overflow));
        check_output("t2_count", 64'(count), 64'd16);
        check_output("t2_oldest_wd", 64'(rd_wd), 64'd5);
        repeat (16) drain_step(1'b1, "t2_drain");
        check_output("t2_done_valid", 64'(rd_valid), 64'd0);

        // Stall halt with an interrupted run first, then backpressure on drain.
        do_clear();
        enter_capture(32'h20);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 32'h30 + 32'(i * 4), 6'd0, 5'(4 + i), 32'hA0 + 32'(i));
        end
        repeat (3) apply_stimulus(1'b1, 1'b0, 32'h40, 6'd0, 5'd0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h44, 6'd0, 5'd0, 32'h0);
        check_output("t3_restart_no_halt", 64'(halted), 64'd0);
        repeat (4) apply_stimulus(1'b1, 1'b0, 32'h40, 6'd0, 5'd0, 32'h0);
        check_output("t3_pre_halt", 64'(halted), 64'd0);
        apply_stimulus(1'b1, 1'b0, 32'h40, 6'd0, 5'd0, 32'h0);
        model_cap = 1'b0;
        en        = 1'b0;
        check_output("t3_halted", 64'(halted), 64'd1);
        check_output("t3_count", 64'(count), 64'd4);
        check_output("t3_cycle_cnt", 64'(cycle_cnt), 64'd13);
        drain_step(1'b1, "t3_bp0");
        drain_step(1'b0, "t3_bp1");
        drain_step(1'b0, "t3_bp2");
        drain_step(1'b1, "t3_bp3");
        check_output("t3_two_pops", 64'(count), 64'd2);
        repeat (2) drain_step(1'b1, "t3_rest");
        check_output("t3_done_valid", 64'(rd_valid), 64'd0);

        // Clear in the middle of a drain, then a fresh capture from pointer 0.
        do_clear();
        enter_capture(32'h0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 32'h200 + 32'(i * 4), 6'd0, 5'(8 + i), 32'hB1 + 32'(i));
        end
        apply_stimulus(1'b1, 1'b0, 32'h20C, HALT, 5'd0, 32'h0);
        model_cap = 1'b0;
        en        = 1'b0;
        drain_step(1'b1, "t4_pop");
        do_clear();
        check_output("t4_clr_count", 64'(count), 64'd0);
        check_output("t4_clr_halted", 64'(halted), 64'd0);
        check_output("t4_clr_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check_output("t4_clr_valid", 64'(rd_valid), 64'd0);
        enter_capture(32'h0);
        apply_stimulus(1'b1, 1'b1, 32'h300, 6'd0, 5'd9, 32'hAB);
        apply_stimulus(1'b1, 1'b0, 32'h304, HALT, 5'd0, 32'h0);
        model_cap = 1'b0;
        en        = 1'b0;
        check_output("t4_new_count", 64'(count), 64'd1);
        drain_step(1'b1, "t4_new");
        check_output("t4_new_done_valid", 64'(rd_valid), 64'd0);

        // Capture pause with en=0, then asynchronous reset between edges.
        do_clear();
        enter_capture(32'h0);
        apply_stimulus(1'b1, 1'b1, 32'h400, 6'd0, 5'd1, 32'hC1);
        apply_stimulus(1'b0, 1'b1, 32'h404, 6'd0, 5'd2, 32'hC2);
        check_output("t5_pause_count", 64'(count), 64'd1);
        check_output("t5_pause_cycle_cnt", 64'(cycle_cnt), 64'd1);
        apply_stimulus(1'b1, 1'b1, 32'h408, 6'd0, 5'd3, 32'hC3);
        check_output("t5_resume_count", 64'(count), 64'd2);
        check_output("t5_resume_cycle_cnt", 64'(cycle_cnt), 64'd2);
        #3;
        reset = 1'b1;
        #1;
        check_output("t5_async_count", 64'(count), 64'd0);
        check_output("t5_async_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check_output("t5_async_halted", 64'(halted), 64'd0);
        check_output("t5_async_valid", 64'(rd_valid), 64'd0);
        tick();
        reset = 1'b0;
        sb.delete();
        model_cap = 1'b0;
        apply_stimulus(1'b0, 1'b1, 32'h500, 6'd0, 5'd1, 32'h1);
        check_output("t5_armed_count", 64'(count), 64'd0);
        check_output("t5_armed_cycle_cnt", 64'(cycle_cnt), 64'd0);
        enter_capture(32'h500);
        check_output("t5_entry_cycle_cnt", 64'(cycle_cnt), 64'd0);
        apply_stimulus(1'b1, 1'b1, 32'h504, 6'd0, 5'd1, 32'hD1);
        check_output("t5_count", 64'(count), 64'd1);
        check_output("t5_cycle_cnt", 64'(cycle_cnt), 64'd1);
        apply_stimulus(1'b1, 1'b0, 32'h508, HALT, 5'd0, 32'h0);
        model_cap = 1'b0;
        en        = 1'b0;
        drain_step(1'b1, "t5_drain");
        check_output("t5_done_valid", 64'(rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
